vdp_text_renderer: RTL and testbench

//  80x30 text-mode pixel renderer (8x16 glyphs) downstream of the VGA sync generator.
//  - Consumes hpos/vpos/display_on/hsync/vsync.
//  - Fetches cell codes and attributes from an external text RAM and glyph rows from an external font ROM.
//  - Emits 12-bit RGB plus syncs delayed to match the fetch pipeline, with a blinking cursor and blink attribute.

---
 rtl/vdp_text_renderer_if.sv | 10 +
 rtl/vdp_text_renderer.sv | 126 ++++++++++++
 tb/tb_vdp_text_renderer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vdp_text_renderer_if.sv
// Read bus between the text renderer and its text RAM / font ROM.
interface vdp_text_renderer_if;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (output text_addr, output font_addr, input text_data, input font_data);
  modport slave  (input text_addr, input font_addr, output text_data, output font_data);
endinterface

// File: rtl/vdp_text_renderer.sv
// 80x30 text-mode renderer: five-stage fetch pipeline from sync-generator positions
// to palette-mapped RGB, with syncs delayed alongside, attribute blink and a cursor.
module vdp_text_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          hpos,
  input  logic [9:0]          vpos,
  input  logic                display_on,
  input  logic                hsync,
  input  logic                vsync,
  vdp_text_renderer_if.master mem,
  input  logic                cursor_en,
  input  logic [6:0]          cursor_col,
  input  logic [4:0]          cursor_row,
  output logic [11:0]         rgb,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                display_on_o
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [6:0] COL_LIM = 7'(COLS);
  localparam logic [5:0] ROW_LIM = 6'(ROWS);

  function automatic logic [3:0] chan(input logic on, input logic bright);
    return (on ? 4'hA : 4'h0) + (bright ? 4'h5 : 4'h0);
  endfunction

  // CGA palette: idx[2:0] selects R/G/B at 0xA, idx[3] lifts all channels by 5; 6 is brown
  function automatic logic [11:0] pal(input logic [3:0] idx);
    logic [3:0] g;
    g = chan(idx[1], idx[3]);
    if (idx == 4'd6) g = 4'h5;
    return {chan(idx[2], idx[3]), g, chan(idx[0], idx[3])};
  endfunction

  logic [6:0]  cell_col;
  logic [5:0]  cell_row;
  logic        cell_ok;
  logic [11:0] cell_addr;
  logic        hit;

  assign cell_col  = hpos[9:3];
  assign cell_row  = vpos[9:4];
  assign cell_ok   = display_on && (cell_col < COL_LIM) && (cell_row < ROW_LIM);
  assign cell_addr = {cell_row, 6'b0} + {2'b0, cell_row, 4'b0} + {5'b0, cell_col};
  assign hit       = cursor_en && (cell_col == cursor_col) && (cell_row == {1'b0, cursor_row});

  logic [2:0] hpix_p1, hpix_p2, hpix_p3, hpix_p4;
  logic [3:0] vline_p1, vline_p2, vline_p3, vline_p4;
  logic       hit_p1, hit_p2, hit_p3, hit_p4;
  logic       vld_p1, vld_p2, vld_p3, vld_p4;
  logic       hs_p1, hs_p2, hs_p3, hs_p4;
  logic       vs_p1, vs_p2, vs_p3, vs_p4;
  logic [3:0] fg_p3, fg_p4;
  logic [2:0] bg_p3, bg_p4;
  logic       blink_p3, blink_p4;

  logic             vs_prev;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             pix;

  always_comb begin
    pix = mem.font_data[~hpix_p4];
    if (blink_p4 && blink_phase) pix = 1'b0;
    if (hit_p4 && !blink_phase && (vline_p4 >= 4'd14)) pix = ~pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.text_addr <= '0;
      hpix_p1 <= '0; vline_p1 <= '0; hit_p1 <= 1'b0; vld_p1 <= 1'b0; hs_p1 <= 1'b1; vs_p1 <= 1'b1;
      hpix_p2 <= '0; vline_p2 <= '0; hit_p2 <= 1'b0; vld_p2 <= 1'b0; hs_p2 <= 1'b1; vs_p2 <= 1'b1;
      mem.font_addr <= '0;
      hpix_p3 <= '0; vline_p3 <= '0; hit_p3 <= 1'b0; vld_p3 <= 1'b0; hs_p3 <= 1'b1; vs_p3 <= 1'b1;
      fg_p3 <= '0; bg_p3 <= '0; blink_p3 <= 1'b0;
      hpix_p4 <= '0; vline_p4 <= '0; hit_p4 <= 1'b0; vld_p4 <= 1'b0; hs_p4 <= 1'b1; vs_p4 <= 1'b1;
      fg_p4 <= '0; bg_p4 <= '0; blink_p4 <= 1'b0;
      rgb <= '0; hsync_o <= 1'b1; vsync_o <= 1'b1; display_on_o <= 1'b0;
    end else begin
      // S1: cell address and cursor compare
      mem.text_addr <= cell_ok ? cell_addr : 12'd0;
      hpix_p1 <= hpos[2:0]; vline_p1 <= vpos[3:0]; hit_p1 <= hit;
      vld_p1 <= display_on; hs_p1 <= hsync; vs_p1 <= vsync;
      // S2: text RAM read in flight
      hpix_p2 <= hpix_p1; vline_p2 <= vline_p1; hit_p2 <= hit_p1;
      vld_p2 <= vld_p1; hs_p2 <= hs_p1; vs_p2 <= vs_p1;
      // S3: attribute split, glyph row address
      mem.font_addr <= {mem.text_data[7:0], vline_p2};
      fg_p3 <= mem.text_data[11:8]; bg_p3 <= mem.text_data[14:12]; blink_p3 <= mem.text_data[15];
      hpix_p3 <= hpix_p2; vline_p3 <= vline_p2; hit_p3 <= hit_p2;
      vld_p3 <= vld_p2; hs_p3 <= hs_p2; vs_p3 <= vs_p2;
      // S4: font ROM read in flight
      fg_p4 <= fg_p3; bg_p4 <= bg_p3; blink_p4 <= blink_p3;
      hpix_p4 <= hpix_p3; vline_p4 <= vline_p3; hit_p4 <= hit_p3;
      vld_p4 <= vld_p3; hs_p4 <= hs_p3; vs_p4 <= vs_p3;
      // S5: pixel select and palette
      rgb <= vld_p4 ? pal(pix ? fg_p4 : {1'b0, bg_p4}) : 12'h000;
      hsync_o <= hs_p4; vsync_o <= vs_p4; display_on_o <= vld_p4;
    end
  end

  // Frame tick on vsync falling edge at the input side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev     <= 1'b1;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vsync;
      if (vs_prev && !vsync) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vdp_text_renderer.sv
// Randomized bench for vdp_text_renderer: each driven position is scored against a
// cell/glyph/palette reference model and compared 1, 3 and 5 clocks later.
module tb_vdp_text_renderer;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        display_on = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o, display_on_o;

  vdp_text_renderer_if bus();

  vdp_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync(hsync), .vsync(vsync), .mem(bus), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .display_on_o(display_on_o)
  );

  always #10 clk = ~clk;

  logic [15:0] ram  [4096];
  logic [7:0]  font [4096];
  logic [11:0] pal_tab [16];

  always @(posedge clk) begin
    bus.text_data <= ram[bus.text_addr];
    bus.font_data <= font[bus.font_addr];
  end

  typedef struct {
    logic [11:0] taddr;
    logic [11:0] faddr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  exp_t hist [8];
  int   cyc = 0;
  int   since = 0;
  int   tk = 0;
  logic pvs = 1'b1;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (since >= 1) chk("text_addr", 32'(bus.text_addr), 32'(hist[(cyc-1)%8].taddr));
    if (since >= 3) chk("font_addr", 32'(bus.font_addr), 32'(hist[(cyc-3)%8].faddr));
    if (since >= 5) begin
      e = hist[(cyc-5)%8];
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("hsync_o", 32'(hsync_o), 32'(e.hs));
      chk("vsync_o", 32'(vsync_o), 32'(e.vs));
      chk("display_on_o", 32'(display_on_o), 32'(e.de));
    end else begin
      chk("rgb_flush", 32'(rgb), 32'h0);
      chk("hsync_o_flush", 32'(hsync_o), 32'h1);
      chk("vsync_o_flush", 32'(vsync_o), 32'h1);
      chk("display_on_o_flush", 32'(display_on_o), 32'h0);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input logic hs, input logic vs);
    exp_t e;
    int a, px, row, col;
    logic [15:0] w;
    logic [7:0] g;
    logic pix, ph;
    logic [3:0] idx;
    hpos = h; vpos = v; display_on = de; hsync = hs; vsync = vs;
    if (pvs && !vs) tk++;
    pvs = vs;
    ph  = ((tk / BF) % 2) == 1;
    col = int'(h) / 8;
    row = int'(v) / 16;
    px  = int'(h) % 8;
    a   = de ? row * 80 + col : 0;
    w   = ram[a];
    g   = font[{w[7:0], v[3:0]}];
    pix = g[7 - px];
    if (w[15] && ph) pix = 1'b0;
    if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && !ph &&
        (int'(v) % 16) >= 14) pix = !pix;
    idx = pix ? w[11:8] : {1'b0, w[14:12]};
    e.taddr = 12'(a);
    e.faddr = {w[7:0], v[3:0]};
    e.rgb   = de ? pal_tab[idx] : 12'h000;
    e.hs = hs; e.vs = vs; e.de = de;
    hist[cyc % 8] = e;
    cyc++;
    since++;
  endtask

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic de,
                      input logic hs, input logic vs);
    @(posedge clk); #1;
    check_out();
    drive(h, v, de, hs, vs);
  endtask

  task automatic vis_random();
    if ($urandom_range(3) == 0)
      step(10'(40 + $urandom_range(7)), 10'(16 + $urandom_range(15)), 1'b1, 1'b1, 1'b1);
    else
      step(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b1, 1'b1, 1'b1);
  endtask

  // Compressed frame: visible samples, a blank stretch with an hsync pulse, then vsync
  task automatic frame(input int nvis);
    int w;
    for (int i = 0; i < nvis; i++) vis_random();
    w = int'($urandom_range(4, 1));
    for (int i = 0; i < 12; i++)
      step(10'(640 + $urandom_range(150)), 10'($urandom_range(524)), 1'b0,
           !(i >= 4 && i < 4 + w), 1'b1);
    w = int'($urandom_range(3, 1));
    for (int i = 0; i < 14; i++)
      step(10'($urandom_range(799)), 10'(480 + $urandom_range(44)), 1'b0, 1'b1,
           !(i >= 6 && i < 6 + w));
    cursor_en = ($urandom_range(4) != 0);
    if ($urandom_range(3) == 0) begin
      cursor_col = 7'($urandom_range(79));
      cursor_row = 5'($urandom_range(29));
    end else begin
      cursor_col = 7'd5;
      cursor_row = 5'd1;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    check_out();
    reset = 1'b1;
    #1;
    chk("async_rgb", 32'(rgb), 32'h0);
    chk("async_hsync_o", 32'(hsync_o), 32'h1);
    chk("async_vsync_o", 32'(vsync_o), 32'h1);
    chk("async_display_on_o", 32'(display_on_o), 32'h0);
    chk("async_text_addr", 32'(bus.text_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rgb", 32'(rgb), 32'h0);
    reset = 1'b0;
    since = 0; tk = 0; pvs = 1'b1;
    drive(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    pal_tab = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 16'($urandom);
      font[i] = 8'($urandom);
    end
    ram[163] = 16'h0F41;
    font[12'h410] = 8'h80;
    ram[85] = 16'h0F20;
    for (int r = 0; r < 16; r++) font[{8'h20, 4'(r)}] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hsync_o", 32'(hsync_o), 32'h1);
    chk("rst_vsync_o", 32'(vsync_o), 32'h1);
    chk("rst_display_on_o", 32'(display_on_o), 32'h0);
    chk("rst_text_addr", 32'(bus.text_addr), 32'h0);
    chk("rst_font_addr", 32'(bus.font_addr), 32'h0);
    reset = 1'b0;
    since = 0; tk = 0; pvs = 1'b1;
    drive(10'd0, 10'd500, 1'b0, 1'b1, 1'b1);

    // Directed fetch example, end-of-screen boundary and wrap
    step(10'd24, 10'd32, 1'b1, 1'b1, 1'b1);
    step(10'd31, 10'd32, 1'b1, 1'b1, 1'b1);
    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(10'd700, 10'd10, 1'b0, 1'b1, 1'b1);

    // Cursor cell swept with blink phase 0
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd1;
    for (int v = 16; v < 32; v++)
      for (int h = 40; h < 48; h++) step(10'(h), 10'(v), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(10'd700, 10'd10, 1'b0, 1'b1, 1'b1);

    for (int f = 0; f < 12; f++) frame(200);

    for (int k = 0; k < 8 && ((tk / BF) % 2) == 0; k++) frame(60);
    for (int i = 0; i < 50; i++) vis_random();
    mid_reset();
    for (int i = 0; i < 100; i++) vis_random();
    for (int i = 0; i < 6; i++) step(10'd700, 10'd10, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 4; f++) frame(150);
    for (int i = 0; i < 6; i++) step(10'd700, 10'd500, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
